chip8_vga_scanout: RTL and testbench

- Scanout controller for the CHIP-8 video path: generates 640x480@60 VGA timing (800x525 total) and drives 4-bit RGB, hsync and vsync.
- Fetches the 64x32 monochrome framebuffer (256 bytes) from shared video memory over a req/ack port during horizontal blanking, into an 8-byte line buffer.
- Each CHIP-8 pixel is scaled 10x10, giving a 640x320 image centred vertically; the rest of the frame is background colour.
- Sits between the video-memory arbiter and the VGA pins or display model.

---
 rtl/chip8_video_pkg.sv | 30 +++
 rtl/chip8_vga_timing.sv | 51 +++++
 rtl/chip8_vga_scanout.sv | 215 +++++++++++++++++++++
 tb/tb_chip8_vga_scanout.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/chip8_video_pkg.sv
// Shared VGA 640x480@60 and CHIP-8 framebuffer constants.
// Also holds the fetch-state encoding and the scanline dimming helper.
package chip8_video_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_TOTAL   = 800;

    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_TOTAL   = 525;

    localparam int FB_W  = 64;
    localparam int FB_H  = 32;
    localparam int SCALE = 10;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_REQ,
        FETCH_DONE
    } fetch_state_e;

    // Halve each 4-bit channel of a {r,g,b} colour.
    function automatic logic [11:0] dim_rgb(input logic [11:0] c);
        return {1'b0, c[11:9], 1'b0, c[7:5], 1'b0, c[3:1]};
    endfunction

endpackage

// File: rtl/chip8_vga_timing.sv
// Free-running 800x525 x/y counters with raw (unregistered) sync and
// visible-area decode; shared by the scanout and later overlays.
module chip8_vga_timing (
    input  logic       clock,
    input  logic       reset,
    output logic [9:0] x_o,
    output logic [9:0] y_o,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       visible_o,
    output logic       line_end_o
);
    import chip8_video_pkg::*;

    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;

    // Next-state for the pixel and line counters.
    always_comb begin
        x_d = x_q + 10'd1;
        y_d = y_q;
        if (x_q == 10'(H_TOTAL - 1)) begin
            x_d = '0;
            y_d = (y_q == 10'(V_TOTAL - 1)) ? '0 : y_q + 10'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o        = x_q;
    assign y_o        = y_q;
    assign line_end_o = (x_q == 10'(H_TOTAL - 1));
    assign visible_o  = (x_q < 10'(H_VISIBLE)) && (y_q < 10'(V_VISIBLE));
    assign hsync_o    = !((x_q >= HS_START) && (x_q < HS_END));
    assign vsync_o    = !((y_q >= VS_START) && (y_q < VS_END));

endmodule

// File: rtl/chip8_vga_scanout.sv
// CHIP-8 64x32 framebuffer scanout to 640x480 VGA, 10x pixel scaling,
// line fetch over req/ack in hblank. Optional: SCANLINE_DIM_EN.
module chip8_vga_scanout #(
    parameter logic [11:0] FG_RGB   = 12'hFFF,
    parameter logic [11:0] BG_RGB   = 12'h000,
    parameter int          V_OFFSET = 80
) (
    input  logic       clock,
    input  logic       reset,
    output logic       mem_req,
    output logic [7:0] mem_addr,
    input  logic       mem_ack,
    input  logic [7:0] mem_rdata,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_tick,
    output logic       underrun
);
    import chip8_video_pkg::*;

    // Line just before CHIP-8 row 0; wraps to the last line when offset is 0.
    localparam logic [9:0] PRE_LINE =
        (V_OFFSET == 0) ? 10'(V_TOTAL - 1) : 10'(V_OFFSET - 1);

    logic [9:0] x, y;
    logic       hs_raw, vs_raw, visible, line_end;

    chip8_vga_timing u_timing (
        .clock      (clock),
        .reset      (reset),
        .x_o        (x),
        .y_o        (y),
        .hsync_o    (hs_raw),
        .vsync_o    (vs_raw),
        .visible_o  (visible),
        .line_end_o (line_end)
    );

    logic [3:0] csub_q, csub_d;
    logic [5:0] col_q, col_d;
    logic [3:0] rsub_q, rsub_d;
    logic [4:0] row_q, row_d;
    logic       in_img_q, in_img_d;

    // Column scaling: col advances every SCALE pixels, restarts each line.
    always_comb begin
        csub_d = csub_q + 4'd1;
        col_d  = col_q;
        if (line_end) begin
            csub_d = '0;
            col_d  = '0;
        end else if (csub_q == 4'(SCALE - 1)) begin
            csub_d = '0;
            col_d  = col_q + 6'd1;
        end
    end

    // Row scaling: starts at V_OFFSET, runs for FB_H rows of SCALE lines.
    always_comb begin
        rsub_d   = rsub_q;
        row_d    = row_q;
        in_img_d = in_img_q;
        if (line_end) begin
            if (y == PRE_LINE) begin
                rsub_d   = '0;
                row_d    = '0;
                in_img_d = 1'b1;
            end else if (in_img_q) begin
                if (rsub_q == 4'(SCALE - 1)) begin
                    rsub_d = '0;
                    if (row_q == 5'(FB_H - 1)) in_img_d = 1'b0;
                    else                       row_d    = row_q + 5'd1;
                end else begin
                    rsub_d = rsub_q + 4'd1;
                end
            end
        end
    end

    // Sub-counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            csub_q   <= '0;
            col_q    <= '0;
            rsub_q   <= '0;
            row_q    <= '0;
            in_img_q <= (V_OFFSET == 0);
        end else begin
            csub_q   <= csub_d;
            col_q    <= col_d;
            rsub_q   <= rsub_d;
            row_q    <= row_d;
            in_img_q <= in_img_d;
        end
    end

    // Fetch the next row on the last line of the current one (or pre-line).
    logic       fetch_go;
    logic [4:0] fetch_row;
    assign fetch_go = (x == 10'(H_VISIBLE)) &&
                      ((y == PRE_LINE) ||
                       (in_img_q && rsub_q == 4'(SCALE - 1) &&
                        row_q != 5'(FB_H - 1)));
    assign fetch_row = (y == PRE_LINE) ? 5'd0 : row_q + 5'd1;

    fetch_state_e state_q;
    logic         mem_req_q;
    logic [7:0]   mem_addr_q;
    logic         buf_valid_q;
    logic         underrun_q;
    logic [7:0]   line_buf_q [8];

    // Fetch FSM: 8 byte reads per row, aborted at end of hblank.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= FETCH_IDLE;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            buf_valid_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            unique case (state_q)
                FETCH_IDLE: begin
                    if (fetch_go) begin
                        state_q    <= FETCH_REQ;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= {fetch_row, 3'd0};
                    end
                end
                FETCH_REQ: begin
                    if (mem_ack && mem_addr_q[2:0] == 3'd7) begin
                        state_q     <= FETCH_DONE;
                        mem_req_q   <= 1'b0;
                        buf_valid_q <= 1'b1;
                    end else begin
                        if (mem_ack) mem_addr_q <= mem_addr_q + 8'd1;
                        if (line_end) begin
                            state_q     <= FETCH_IDLE;
                            mem_req_q   <= 1'b0;
                            buf_valid_q <= 1'b0;
                            underrun_q  <= 1'b1;
                        end
                    end
                end
                FETCH_DONE: begin
                    buf_valid_q <= 1'b1;
                    state_q     <= FETCH_IDLE;
                end
                default: state_q <= FETCH_IDLE;
            endcase
        end
    end

    // Line buffer capture of accepted bytes.
    always_ff @(posedge clock) begin
        if (!reset && state_q == FETCH_REQ && mem_ack) begin
            line_buf_q[mem_addr_q[2:0]] <= mem_rdata;
        end
    end

    logic [7:0]  cur_byte;
    logic        pix_bit;
    logic [11:0] fg_c, bg_c, rgb_d;

    assign cur_byte = line_buf_q[col_q[5:3]];
    assign pix_bit  = cur_byte[3'd7 - col_q[2:0]];

`ifdef SCANLINE_DIM_EN
    assign fg_c = y[0] ? dim_rgb(FG_RGB) : FG_RGB;
    assign bg_c = y[0] ? dim_rgb(BG_RGB) : BG_RGB;
`else
    assign fg_c = FG_RGB;
    assign bg_c = BG_RGB;
`endif

    // Pixel colour select; blanking forces black.
    always_comb begin
        rgb_d = 12'h000;
        if (visible) begin
            rgb_d = (in_img_q && buf_valid_q && pix_bit) ? fg_c : bg_c;
        end
    end

    logic [11:0] rgb_q;
    logic        hsync_q, vsync_q, tick_q;

    // Output registers, one cycle behind the counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            rgb_q   <= 12'h000;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            tick_q  <= 1'b0;
        end else begin
            rgb_q   <= rgb_d;
            hsync_q <= hs_raw;
            vsync_q <= vs_raw;
            tick_q  <= (x == 10'd0) && (y == 10'(V_VISIBLE));
        end
    end

    assign red        = rgb_q[11:8];
    assign green      = rgb_q[7:4];
    assign blue       = rgb_q[3:0];
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign frame_tick = tick_q;
    assign underrun   = underrun_q;
    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;

endmodule

// File: tb/tb_chip8_vga_scanout.sv
// Self-checking bench for chip8_vga_scanout: spot-check tables plus a
// per-cycle reference model of the frame computed from pixel coordinates.
module tb_chip8_vga_scanout;

    localparam int          VO = 4;
    localparam logic [11:0] FG = 12'hEEE;
    localparam logic [11:0] BG = 12'h123;
`ifdef SCANLINE_DIM_EN
    localparam bit DIM = 1'b1;
`else
    localparam bit DIM = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ack = 1'b0;
    logic [7:0] mem_rdata = 8'h00;
    logic [3:0] red, green, blue;
    logic       hsync, vsync, frame_tick, underrun;

    always #20 clock = ~clock;

    chip8_vga_scanout #(
        .FG_RGB   (FG),
        .BG_RGB   (BG),
        .V_OFFSET (VO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .hsync      (hsync),
        .vsync      (vsync),
        .frame_tick (frame_tick),
        .underrun   (underrun)
    );

    typedef struct {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        tick;
        logic        und;
    } exp_t;

    typedef struct {
        int          x;
        int          y;
        logic [11:0] rgb;
    } probe_t;

    logic [7:0]  fb [256];
    logic [11:0] cap [16][800];
    probe_t      tbl [20];
    int          stall_addr = -1;
    int          stall_row  = -1;
    int          checks = 0;
    int          passed = 0;

    // Video memory: acks every other cycle while req is high, except a
    // stalled address which is never acknowledged.
    always @(negedge clock) begin
        mem_ack   = (mem_req === 1'b1) && !mem_ack &&
                    (int'(mem_addr) != stall_addr);
        mem_rdata = mem_ack ? fb[mem_addr] : 8'h00;
    end

    task automatic check(input bit ok, input string name, input string detail);
        checks++;
        if (ok) passed++;
        else $display("FAIL %s: %s", name, detail);
    endtask

    function automatic logic [11:0] shade(input logic [11:0] c, input int y);
        logic [11:0] r;
        r = c;
        if (DIM && (y % 2 == 1))
            r = {4'(c[11:8] / 2), 4'(c[7:4] / 2), 4'(c[3:0] / 2)};
        return r;
    endfunction

    // Expected registered outputs for the pixel at cycle m after reset.
    function automatic exp_t model(input int m);
        exp_t        e;
        int          x, y, r, c;
        logic [7:0]  b;
        x      = m % 800;
        y      = (m / 800) % 525;
        e.hs   = !(x >= 656 && x <= 751);
        e.vs   = !(y >= 490 && y <= 491);
        e.tick = (x == 0 && y == 480);
        e.und  = (stall_row >= 0) &&
                 (m >= (VO - 1 + 10 * stall_row) * 800 + 799);
        e.rgb  = 12'h000;
        if (x < 640 && y < 480) begin
            e.rgb = BG;
            if (y >= VO && y < VO + 320) begin
                r = (y - VO) / 10;
                c = x / 10;
                b = fb[r * 8 + c / 8];
                if (r != stall_row && b[7 - c % 8]) e.rgb = FG;
            end
            e.rgb = shade(e.rgb, y);
        end
        return e;
    endfunction

    // Run nc cycles from cycle 0, comparing one scan line per check.
    task automatic run(input int nc);
        exp_t        e;
        logic [11:0] got;
        int          bad, y, xn, yn;
        string       first;
        bad   = 0;
        first = "";
        for (int m = 0; m < nc; m++) begin
            @(negedge clock);
            e   = model(m);
            got = {red, green, blue};
            y   = m / 800;
            if (y < 16) cap[y][m % 800] = got;
            if (got !== e.rgb || hsync !== e.hs || vsync !== e.vs ||
                frame_tick !== e.tick || underrun !== e.und) begin
                if (bad == 0)
                    first = $sformatf(
                        "x=%0d rgb %h/%h hs %b/%b vs %b/%b tick %b/%b und %b/%b",
                        m % 800, got, e.rgb, hsync, e.hs, vsync, e.vs,
                        frame_tick, e.tick, underrun, e.und);
                bad++;
            end
            xn = (m + 1) % 800;
            yn = ((m + 1) / 800) % 525;
            if (mem_req !== 1'b0 &&
                (mem_req !== 1'b1 || xn < 641 ||
                 int'(mem_addr[7:3]) != (yn + 1 - VO) / 10)) begin
                if (bad == 0)
                    first = $sformatf("x=%0d mem_req %b addr %h outside hblank fetch",
                                      xn, mem_req, mem_addr);
                bad++;
            end
            if (m % 800 == 799 || m == nc - 1)
            begin
                check(bad == 0, $sformatf("line%0d", y),
                      $sformatf("%0d cycles got/required differ, first %s",
                                bad, first));
                bad = 0;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({red, green, blue} === 12'h000, {tag, "_rgb"},
              $sformatf("got %h required 000", {red, green, blue}));
        check(hsync === 1'b1 && vsync === 1'b1, {tag, "_sync"},
              $sformatf("got hs=%b vs=%b required 1/1", hsync, vsync));
        check(mem_req === 1'b0 && mem_addr === 8'h00, {tag, "_mem"},
              $sformatf("got req=%b addr=%h required 0/00", mem_req, mem_addr));
        check(frame_tick === 1'b0 && underrun === 1'b0, {tag, "_flags"},
              $sformatf("got tick=%b und=%b required 0/0", frame_tick, underrun));
    endtask

    // Reset, release, and leave the simulation inside cycle 0.
    task automatic start();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1 check_reset_outputs("reset");
    endtask

    task automatic probes(input int lo, input string tag);
        logic [11:0] req;
        for (int i = lo; i < lo + 10; i++) begin
            req = shade(tbl[i].rgb, tbl[i].y);
            check(cap[tbl[i].y][tbl[i].x] === req,
                  $sformatf("%s_x%0d_y%0d", tag, tbl[i].x, tbl[i].y),
                  $sformatf("got %h required %h",
                            cap[tbl[i].y][tbl[i].x], req));
        end
    endtask

    initial begin
        tbl[0]  = '{0, 4, FG};
        tbl[1]  = '{9, 4, FG};
        tbl[2]  = '{10, 4, BG};
        tbl[3]  = '{9, 13, FG};
        tbl[4]  = '{0, 14, BG};
        tbl[5]  = '{5, 3, BG};
        tbl[6]  = '{639, 8, BG};
        tbl[7]  = '{640, 4, 12'h000};
        tbl[8]  = '{799, 10, 12'h000};
        tbl[9]  = '{5, 9, FG};
        tbl[10] = '{0, 4, FG};
        tbl[11] = '{9, 5, FG};
        tbl[12] = '{10, 6, BG};
        tbl[13] = '{19, 7, BG};
        tbl[14] = '{20, 8, FG};
        tbl[15] = '{629, 13, FG};
        tbl[16] = '{639, 12, BG};
        tbl[17] = '{0, 3, BG};
        tbl[18] = '{0, 14, FG};
        tbl[19] = '{650, 14, 12'h000};

        // Single lit pixel at top-left of the image.
        for (int i = 0; i < 256; i++) fb[i] = 8'h00;
        fb[0] = 8'h80;
        start();
        run(16 * 800);
        probes(0, "pix80");

        // Checkerboard stripes.
        for (int i = 0; i < 256; i++) fb[i] = 8'hAA;
        start();
        run(16 * 800);
        probes(10, "checker");

        // Random image with row 0 fetch stalled after a random byte count.
        for (int i = 0; i < 256; i++) fb[i] = 8'($urandom);
        stall_row  = 0;
        stall_addr = int'($urandom_range(0, 7));
        start();
        run(25 * 800);
        check(underrun === 1'b1, "underrun_sticky",
              $sformatf("got %b required 1", underrun));

        // Reset while a fetch is stuck on byte 3 of row 0.
        stall_row  = -1;
        stall_addr = 3;
        for (int i = 0; i < 256; i++) fb[i] = 8'($urandom);
        start();
        run(3 * 800 + 700);
        check(mem_req === 1'b1 && mem_addr === 8'h03, "fetch_at_byte3",
              $sformatf("got req=%b addr=%h required 1/03", mem_req, mem_addr));
        check(hsync === 1'b0, "hsync_before_reset",
              $sformatf("got %b required 0", hsync));
        reset = 1'b1;
        @(posedge clock);
        #1 check_reset_outputs("midfetch");
        @(negedge clock);
        reset      = 1'b0;
        stall_addr = -1;
        #1 check_reset_outputs("restart");
        run(16 * 800);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
